// File: rtl/mips86_fetch_pkg.sv
// Shared definitions for the opcode prefetch path: byte-fetch FSM states and
// the width of the byte-within-word index.
package mips86_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetchState_t;

    // Enough for WORD_BYTES up to 4.
    localparam int BYTE_IDX_W = 2;
endpackage

// File: rtl/opcode_fifo.sv
// Power-of-two circular queue of {opcode, address} entries with head/tail/count.
// Storage itself is not reset; only the pointers and count are.
module opcode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic             doPop, doPush;

    assign doPop  = pop && (count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign doPush = push && ((count != FULL_CNT) || doPop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) tail <= tail + 1'b1;
            if (doPop)  head <= head + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush && !reset) mem[tail] <= pushData;
    end

    assign headData = mem[head];
endmodule

// File: rtl/opcode_prefetch_queue.sv
// Opcode prefetcher: reads bytes one at a time from the MMU, assembles them
// big-endian into words and queues {word, address} for the decoder.
module opcode_prefetch_queue #(
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       ip,
    input  logic                    redirect,
    input  logic                    take,
    output logic                    opcodeValid,
    output logic [8*WORD_BYTES-1:0] opcode,
    output logic [ADDR_W-1:0]       opcodeAddr,
    output logic [ADDR_W-1:0]       memAddr,
    output logic                    memRequest,
    input  logic [7:0]              memData,
    input  logic                    memBusy
);
    import mips86_fetch_pkg::*;

    localparam int OPW     = 8*WORD_BYTES;
    localparam int ENTRY_W = OPW + ADDR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    fetchState_t           state, stateNext;
    logic [ADDR_W-1:0]     fetchPtr;
    logic [BYTE_IDX_W-1:0] byteIdx;
    logic [OPW-1:0]        asmWord, wordNext;
    logic [ENTRY_W-1:0]    headData;
    logic [CNT_W-1:0]      count;
    logic                  capture, lastByte, push, notFull;

    assign lastByte = (byteIdx == BYTE_IDX_W'(WORD_BYTES-1));
    assign capture  = (state == WAIT) && !memBusy && !redirect;
    assign push     = capture && lastByte;
    assign notFull  = (count != CNT_W'(DEPTH));
    // Held stable across REQ/WAIT: fetchPtr and byteIdx only move at capture.
    assign memAddr  = fetchPtr + ADDR_W'(byteIdx);

    always_comb begin
        wordNext = asmWord;
        for (int k = 0; k < WORD_BYTES; k++)
            if (byteIdx == BYTE_IDX_W'(k)) wordNext[8*(WORD_BYTES-1-k) +: 8] = memData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetchPtr <= '0;
            byteIdx  <= '0;
            asmWord  <= '0;
        end else begin
            state <= stateNext;
            if (redirect) begin
                fetchPtr <= ip;
                byteIdx  <= '0;
            end else if (capture) begin
                asmWord <= wordNext;
                if (lastByte) begin
                    byteIdx  <= '0;
                    fetchPtr <= fetchPtr + ADDR_W'(WORD_BYTES);
                end else begin
                    byteIdx <= byteIdx + 1'b1;
                end
            end
        end
    end

    // Every path back to REQ goes through IDLE, which waits for memBusy=0;
    // this covers redirect and reset while the MMU still owns a request.
    always_comb begin
        stateNext  = state;
        memRequest = 1'b0;
        case (state)
            IDLE: if (!redirect && !memBusy && notFull) stateNext = REQ;
            REQ: begin
                memRequest = 1'b1;
                if (redirect)     stateNext = IDLE;
                else if (memBusy) stateNext = WAIT;
            end
            WAIT: if (redirect || !memBusy) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    opcode_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (push),
        .pushData ({wordNext, fetchPtr}),
        .pop      (take && !redirect),
        .headData (headData),
        .count    (count)
    );

    assign opcodeValid = (count != '0);
    assign opcode      = headData[ENTRY_W-1 -: OPW];
    assign opcodeAddr  = headData[ADDR_W-1:0];
endmodule

// File: tb/tb_opcode_prefetch_queue.sv
// Bench: MMU model with variable latency, directed scenarios, then randomized
// take/redirect traffic checked against a consecutive-address stream model.
module tb_opcode_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset, redirect, take;
    logic [31:0] ip;
    logic        opcodeValid, memRequest;
    logic [31:0] opcode, opcodeAddr, memAddr;
    logic [7:0]  memData;
    logic        memBusy;

    int nCmp = 0, nBad = 0;
    logic        mmuBusy = 1'b0;
    logic [31:0] mmuAddr = '0;
    int          mmuCnt = 0, latMin = 3, latMax = 3;
    logic        reqPrev = 1'b0;

    always #5 clk = ~clk;

    opcode_prefetch_queue #(.DEPTH(4), .WORD_BYTES(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .ip(ip), .redirect(redirect), .take(take),
        .opcodeValid(opcodeValid), .opcode(opcode), .opcodeAddr(opcodeAddr),
        .memAddr(memAddr), .memRequest(memRequest), .memData(memData), .memBusy(memBusy)
    );

    function automatic logic [7:0] memByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = {w[23:0], memByte(a + 32'(k))};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MMU: accepts a request when idle, stays busy for a random number of cycles.
    assign memBusy = mmuBusy;
    assign memData = memByte(mmuAddr);
    always @(posedge clk) begin
        if (!mmuBusy) begin
            if (memRequest) begin
                mmuAddr <= memAddr;
                mmuBusy <= 1'b1;
                mmuCnt  <= int'($urandom_range(latMax, latMin));
            end
        end else if (mmuCnt <= 1) mmuBusy <= 1'b0;
        else mmuCnt <= mmuCnt - 1;
    end

    // Protocol monitor: no new request while busy; address held while requesting.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reqRiseBusy", memRequest && !reqPrev && mmuBusy, 0);
            if (memRequest && mmuBusy) chk("addrHold", memAddr, mmuAddr);
        end
        reqPrev <= memRequest;
    end

    initial begin
        int n;
        logic [31:0] expAddr;
        logic        expEmpty;
        reset = 1'b1; redirect = 1'b0; take = 1'b0; ip = '0;
        repeat (3) @(negedge clk);
        chk("rstValid", opcodeValid, 0);
        chk("rstReq", memRequest, 0);
        chk("rstAddr", memAddr, 0);
        reset = 1'b0;

        // Fill the queue from address 0 with no consumer.
        redirect = 1'b1; ip = '0;
        @(negedge clk); redirect = 1'b0;
        repeat (200) @(negedge clk);
        chk("fullValid", opcodeValid, 1);
        chk("fullHead", opcode, 32'h00010203);
        chk("fullHeadAddr", opcodeAddr, 0);
        for (int i = 0; i < 5; i++) begin
            chk("fullNoReq", memRequest, 0);
            @(negedge clk);
        end

        // One take: head advances and prefetch resumes at 0x10.
        take = 1'b1; @(negedge clk); take = 1'b0;
        chk("takeHead", opcode, 32'h04050607);
        chk("takeHeadAddr", opcodeAddr, 32'h4);
        n = 0;
        while (!memRequest && n < 20) begin @(negedge clk); n++; end
        chk("resumeTimeout", n < 20, 1);
        chk("resumeAddr", memAddr, 32'h10);

        // Redirect to 0x8 while waiting on byte 2 of the word at 0x4.
        redirect = 1'b1; ip = '0;
        @(negedge clk); redirect = 1'b0;
        n = 0;
        while (!(mmuBusy && !memRequest && mmuAddr == 32'h6) && n < 200) begin @(negedge clk); n++; end
        chk("waitB2Timeout", n < 200, 1);
        redirect = 1'b1; ip = 32'h8;
        @(negedge clk); redirect = 1'b0;
        chk("redirFlush", opcodeValid, 0);
        n = 0;
        while (!opcodeValid && n < 200) begin @(negedge clk); n++; end
        chk("redirTimeout", n < 200, 1);
        chk("redirHead", opcode, 32'h08090A0B);
        chk("redirHeadAddr", opcodeAddr, 32'h8);

        // Address wrap at the top of the space.
        redirect = 1'b1; ip = 32'hFFFF_FFFC;
        @(negedge clk); redirect = 1'b0;
        n = 0;
        while (!opcodeValid && n < 200) begin @(negedge clk); n++; end
        chk("wrapTimeout", n < 200, 1);
        chk("wrapHead", opcode, wordAt(32'hFFFF_FFFC));
        chk("wrapHeadAddr", opcodeAddr, 32'hFFFF_FFFC);
        n = 0;
        while (!memRequest && n < 50) begin @(negedge clk); n++; end
        chk("wrapReqTimeout", n < 50, 1);
        chk("wrapReqAddr", memAddr, 0);

        // Reset while the MMU is busy.
        latMin = 6; latMax = 6;
        redirect = 1'b1; ip = 32'h100;
        @(negedge clk); redirect = 1'b0;
        n = 0;
        while (!(mmuBusy && !memRequest) && n < 100) begin @(negedge clk); n++; end
        chk("busyTimeout", n < 100, 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rstBusyReq", memRequest, 0);
        chk("rstBusyValid", opcodeValid, 0);
        n = 0;
        while (mmuBusy && n < 20) begin
            chk("rstNoReq", memRequest, 0);
            @(negedge clk); n++;
        end
        n = 0;
        while (!memRequest && n < 20) begin @(negedge clk); n++; end
        chk("rstReqTimeout", n < 20, 1);
        chk("rstReqAddr", memAddr, 0);

        // Randomized traffic: first continuous take, then random take/redirect.
        latMin = 1; latMax = 3;
        redirect = 1'b1; ip = $urandom; expAddr = ip; expEmpty = 1'b1;
        @(negedge clk); redirect = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (expEmpty) chk("rndFlush", opcodeValid, 0);
            if (opcodeValid) begin
                chk("rndOpcode", opcode, wordAt(expAddr));
                chk("rndAddr", opcodeAddr, expAddr);
            end
            take     = (cyc < 600) ? 1'b1 : ($urandom_range(1) == 1);
            redirect = (cyc >= 600) && ($urandom_range(99) < 3);
            ip       = $urandom;
            expEmpty = redirect;
            if (redirect) expAddr = ip;
            else if (take && opcodeValid) expAddr = expAddr + 32'd4;
            @(negedge clk);
        end
        take = 1'b0; redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/opcode_prefetch_queue.md
OPCODE_PREFETCH_QUEUE -- requirements
Module: opcode_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 Parameter WORD_BYTES, default 4, meaning bytes per opcode (1..4).
REQ-003 Parameter ADDR_W, default 32, meaning address width.
REQ-004 Port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, meaning synchronous active-high reset.
REQ-006 Port ip, input, ADDR_W, meaning new fetch address, sampled when redirect=1.
REQ-007 Port redirect, input, 1, meaning flush the queue and restart prefetch at ip.
REQ-008 Port take, input, 1, meaning the consumer pops the head entry.
REQ-009 Port opcodeValid, output, 1, meaning the queue is non-empty.
REQ-010 Port opcode, output, 8*WORD_BYTES, meaning the head opcode.
REQ-011 Port opcodeAddr, output, ADDR_W, meaning the byte address of the head opcode.
REQ-012 Port memAddr, output, ADDR_W, meaning the byte address requested from the MMU.
REQ-013 Port memRequest, output, 1, meaning a byte-read request is active.
REQ-014 Port memData, input, 8, meaning the MMU read byte.
REQ-015 Port memBusy, input, 1, meaning the MMU is servicing a request.

Function
REQ-016 The FSM shall have three states: IDLE (no request), REQ (memRequest=1 until memBusy=1 is sampled), and WAIT (memRequest=0 until memBusy=0 is sampled, then capture memData).
REQ-017 Each byte shall cost at least 2 cycles; memAddr shall stay stable from REQ entry until the byte is captured.
REQ-018 Byte k (0..WORD_BYTES-1) of a word at address A shall be read from A+k and placed big-endian, so byte 0 lands in the MSB.
REQ-019 The last byte of a word shall write {assembled word, A} into the tail entry in the capture cycle, and opcodeValid shall rise on the next cycle.
REQ-020 After each pushed word the fetch pointer shall advance by WORD_BYTES, modulo 2^ADDR_W (wrap from all-ones to 0 is legal).
REQ-021 When count=DEPTH the FSM shall stay in IDLE and issue no request; it shall resume the cycle after a take.
REQ-022 take with count=0 shall be ignored.
REQ-023 A simultaneous take and push shall leave count unchanged, and a push into a full queue shall be allowed when a take occurs in the same cycle.
REQ-024 redirect shall take effect the next cycle: count=0, opcodeValid=0, fetch pointer=ip, and the byte index cleared.
REQ-025 redirect shall override a take or push in the same cycle.
REQ-026 On redirect during WAIT, the in-flight byte shall be discarded; the FSM shall wait for memBusy=0 before entering REQ at the new address.
REQ-027 On redirect during REQ, memRequest shall drop, and the FSM shall wait for memBusy=0 before re-requesting.
REQ-028 opcode and opcodeAddr shall be combinational from the head entry and are don't-care when opcodeValid=0.
REQ-029 The block shall never hold memRequest=1 while the previous request has memBusy=1.

Reset
REQ-030 On reset=1 at a clk edge, the FSM shall go to IDLE, with count=0, head=tail=0, and byte index=0.
REQ-031 On reset, the fetch pointer shall be 0, with opcodeValid=0, memRequest=0, and memAddr=0.
REQ-032 Reset mid-transaction shall abandon the transaction; the first request after reset shall be at address 0 once memBusy=0.
REQ-033 Queue storage need not be reset.

Structure
REQ-034 The FSM state encodings and the byte-index width constant shall live in the shared package mips86_fetch_pkg.
REQ-035 The word storage plus head/tail/count logic shall be one sub-module, opcode_fifo (DEPTH, width 8*WORD_BYTES+ADDR_W).
REQ-036 The byte-fetch FSM and word assembly shall live in the top-level module.

Verification
REQ-037 Memory bytes 00..0F, reset, then redirect with ip=0 and no take -> four words 00010203, 04050607, 08090A0B, 0C0D0E0F are queued, opcodeValid=1, and memRequest stays 0 once full.
REQ-038 Full queue, then one take -> opcode goes from 00010203 to 04050607, and the next request is at memAddr=0x10.
REQ-039 Redirect with ip=0x8 issued during WAIT on byte 2 of word 0x4 -> the old byte is dropped, and the next head is 08090A0B with opcodeAddr=0x8.
REQ-040 ip=0xFFFFFFFC with WORD_BYTES=4 -> the first word is read from FFFFFFFC..FFFFFFFF, and the next request is at 0x0.
REQ-041 Continuous take every cycle while prefetching -> count never exceeds 1, with no lost or duplicated word (addresses are consecutive).
REQ-042 Reset asserted while memBusy=1 -> memRequest=0, and no request until memBusy=0; then a request at address 0.
